// File: rtl/polar_enc_kernel_if.sv
// Frame-in / codeword-word-out bundle of the N=256 polar encoder kernel.
// The slave side is the kernel; the master side is its environment.
interface polar_enc_kernel_if #(
    parameter int DW = 32
);
    logic           vld_i;
    logic [255:0]   din;
    logic           rdy_o;
    logic           err_o;
    logic [DW-1:0]  dout;
    logic           vld_o;
    logic           rdy_i;
    logic           sop_o;
    logic           eop_o;

    modport master (
        output vld_i, din, rdy_i,
        input  rdy_o, err_o, dout, vld_o, sop_o, eop_o
    );

    modport slave (
        input  vld_i, din, rdy_i,
        output rdy_o, err_o, dout, vld_o, sop_o, eop_o
    );
endinterface

// File: rtl/polar_enc_kernel.sv
// Iterative polar transform x = u * F^(x8), one butterfly stage per cycle,
// followed by a DW-bit word stream of the codeword under valid/ready.
module polar_enc_kernel #(
    parameter int LOG_N = 8,
    parameter int DW    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    polar_enc_kernel_if.slave    bus
);
    localparam int N   = 1 << LOG_N;
    localparam int NW  = N / DW;
    localparam int WCW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    wbuf_q, wbuf_d;
    logic [2:0]      stg_q, stg_d;
    logic [WCW-1:0]  wc_q, wc_d;
    logic            err_q, err_d;
    logic            last_w;

    // One butterfly stage: pairs (lo, lo+h) with bit s of lo clear,
    // lo <= lo ^ hi, hi unchanged. lo is built by inserting a 0 at bit s.
    function automatic logic [N-1:0] bfly(input logic [N-1:0] v,
                                          input logic [2:0]   s);
        logic [N-1:0] r;
        logic [7:0]   iw;
        logic [7:0]   m;
        logic [7:0]   lo;
        logic [7:0]   hi;
        r = v;
        m = (8'd1 << s) - 8'd1;
        for (int i = 0; i < N / 2; i++) begin
            iw    = 8'(i);
            lo    = ((iw & ~m) << 1) | (iw & m);
            hi    = lo | (8'd1 << s);
            r[lo] = v[lo] ^ v[hi];
        end
        return r;
    endfunction

    assign last_w = (wc_q == WCW'(NW - 1));

    // Next-state, datapath and drop-detect decode.
    always_comb begin
        state_d = state_q;
        wbuf_d  = wbuf_q;
        stg_d   = stg_q;
        wc_d    = wc_q;
        err_d   = bus.vld_i && (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (bus.vld_i) begin
                    wbuf_d  = bus.din;
                    stg_d   = 3'd0;
                    state_d = CALC;
                end
            end
            CALC: begin
                wbuf_d = bfly(wbuf_q, stg_q);
                stg_d  = stg_q + 3'd1;
                if (stg_q == 3'd7) begin
                    wc_d    = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.rdy_i) begin
                    if (last_w) begin
                        wc_d    = '0;
                        state_d = IDLE;
                    end else begin
                        wc_d = wc_q + WCW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wbuf_q  <= '0;
            stg_q   <= '0;
            wc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wbuf_q  <= wbuf_d;
            stg_q   <= stg_d;
            wc_q    <= wc_d;
            err_q   <= err_d;
        end
    end

    assign bus.rdy_o = (state_q == IDLE);
    assign bus.err_o = err_q;
    assign bus.vld_o = (state_q == SEND);
    assign bus.sop_o = (state_q == SEND) && (wc_q == '0);
    assign bus.eop_o = (state_q == SEND) && last_w;
    assign bus.dout  = (state_q == SEND) ? wbuf_q[int'(wc_q) * DW +: DW]
                                         : '0;
endmodule

// File: tb/tb_polar_enc_kernel.sv
// Directed bench for polar_enc_kernel at DW=32.
// Expected codewords come from hand values and a subset-XOR model.
module tb_polar_enc_kernel;
    localparam int DW = 32;
    localparam int NW = 256 / DW;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    polar_enc_kernel_if #(.DW(DW)) bus ();

    polar_enc_kernel #(.LOG_N(8), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // x_j = XOR of u_i over every i whose bits cover the bits of j
    function automatic logic [255:0] enc(input logic [255:0] u);
        logic [255:0] x;
        logic         acc;
        for (int j = 0; j < 256; j++) begin
            acc = 1'b0;
            for (int i = 0; i < 256; i++)
                if ((i & j) == j) acc ^= u[i];
            x[j] = acc;
        end
        return x;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [255:0] u);
        bus.din   = u;
        bus.vld_i = 1'b1;
        tick();
        bus.vld_i = 1'b0;
    endtask

    // Drains one frame; rnd gives 50% rdy_i, poke raises vld_i on the
    // last handshake so that frame must be dropped.
    task automatic collect(input logic [255:0] x, input bit rnd,
                           input bit poke);
        int n   = 0;
        int cyc = 0;
        logic [DW-1:0] w;
        while (n < NW && cyc < 400) begin
            bus.rdy_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.vld_o) begin
                w = x[n*DW +: DW];
                chk("word", 256'(bus.dout), 256'(w));
                chk("sop", 256'(bus.sop_o), 256'(n == 0));
                chk("eop", 256'(bus.eop_o), 256'(n == NW - 1));
                if (bus.rdy_i) begin
                    if (poke && n == NW - 1) begin
                        bus.din   = rnd256();
                        bus.vld_i = 1'b1;
                    end
                    n++;
                end
            end
            tick();
            cyc++;
        end
        bus.vld_i = 1'b0;
        bus.rdy_i = 1'b1;
        chk("handshakes", 256'(n), 256'(NW));
        chk("err_after", 256'(bus.err_o), 256'(poke));
        chk("rdy_after", 256'(bus.rdy_o), 256'd1);
        chk("vld_after", 256'(bus.vld_o), 256'd0);
    endtask

    initial begin
        logic [255:0] u;
        logic [255:0] x;
        bit           seen;

        rst       = 1'b1;
        bus.vld_i = 1'b0;
        bus.din   = '0;
        bus.rdy_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", 256'(bus.rdy_o), 256'd1);
        chk("rst_vld", 256'(bus.vld_o), 256'd0);
        chk("rst_err", 256'(bus.err_o), 256'd0);
        chk("rst_sop", 256'(bus.sop_o), 256'd0);
        chk("rst_eop", 256'(bus.eop_o), 256'd0);
        chk("rst_dout", 256'(bus.dout), 256'd0);
        rst = 1'b0;
        tick();

        // latency: capture in cycle 0, sop in 9, eop in 16, idle in 17
        u = 256'd1;
        send_frame(u);
        chk("lat_rdy_c1", 256'(bus.rdy_o), 256'd0);
        repeat (7) tick();
        chk("lat_vld_c8", 256'(bus.vld_o), 256'd0);
        tick();
        chk("lat_vld_c9", 256'(bus.vld_o), 256'd1);
        chk("lat_sop_c9", 256'(bus.sop_o), 256'd1);
        collect(256'd1, 1'b0, 1'b0);

        // back-to-back capture in cycle 17: bit 255 -> all ones
        u      = '0;
        u[255] = 1'b1;
        send_frame(u);
        collect({256{1'b1}}, 1'b0, 1'b0);

        // bit 1 -> x = 3
        send_frame(256'd2);
        collect(256'd3, 1'b0, 1'b0);

        // overflow during CALC: err in cycle 5 only
        u = rnd256();
        send_frame(u);
        tick();
        tick();
        chk("ovf_err_c3", 256'(bus.err_o), 256'd0);
        tick();
        bus.din   = rnd256();
        bus.vld_i = 1'b1;
        tick();
        bus.vld_i = 1'b0;
        chk("ovf_err_c5", 256'(bus.err_o), 256'd1);
        tick();
        chk("ovf_err_c6", 256'(bus.err_o), 256'd0);
        collect(enc(u), 1'b0, 1'b0);

        // backpressure with random rdy_i
        for (int f = 0; f < 3; f++) begin
            u = rnd256();
            send_frame(u);
            collect(enc(u), 1'b1, 1'b0);
        end

        // vld_i on the final handshake is dropped
        u = rnd256();
        send_frame(u);
        collect(enc(u), 1'b0, 1'b1);
        tick();
        chk("poke_err_clr", 256'(bus.err_o), 256'd0);
        repeat (12) tick();
        chk("poke_no_cap", 256'(bus.vld_o), 256'd0);

        // asynchronous reset in the middle of a stalled SEND
        u = rnd256();
        send_frame(u);
        bus.rdy_i = 1'b0;
        repeat (10) tick();
        chk("mid_vld", 256'(bus.vld_o), 256'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_vld", 256'(bus.vld_o), 256'd0);
        chk("arst_dout", 256'(bus.dout), 256'd0);
        chk("arst_rdy", 256'(bus.rdy_o), 256'd1);
        tick();
        rst       = 1'b0;
        bus.rdy_i = 1'b1;
        seen      = 1'b0;
        repeat (15) begin
            tick();
            if (bus.vld_o) seen = 1'b1;
        end
        chk("no_residual", 256'(seen), 256'd0);
        u = rnd256();
        send_frame(u);
        collect(enc(u), 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/polar_enc_kernel.md
# polar_enc_kernel

Iterative polar-transform kernel for the N=256 encoder. It consumes the 256-bit frozen-bit-expanded vector u (bit i = u_i, frozen positions already zero) from the bit-mixing stage directly upstream. It computes the codeword x = u·F^⊗8 with F = [[1,0],[1,1]], one butterfly stage per cycle, then streams x out in DW-bit words under a valid/ready handshake.

## Interface
- LOG_N, default 8: log2 of the frame length. Only 8 is supported, giving N=256.
- DW, default 32: output word width. Must divide 256; legal values are 8, 16, 32, 64, 128, 256.
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- vld_i  in  1  one-cycle frame strobe from the upstream stage. That stage has no backpressure input.
- din  in  256  u vector, sampled only when vld_i=1.
- rdy_o  out  1  high when a frame can be captured (state IDLE).
- err_o  out  1  one-cycle pulse: vld_i arrived while rdy_o=0 and the frame was dropped.
- dout  out  DW  codeword word.
- vld_o  out  1  dout valid.
- rdy_i  in  1  downstream accepts dout. A word transfers on vld_o && rdy_i.
- sop_o  out  1  first word of the frame, qualified by vld_o.
- eop_o  out  1  last word of the frame, qualified by vld_o.

## Operation
- Storage:
  - 256-bit working register buf.
  - 3-bit stage counter stg.
  - word counter wc, width log2(256/DW), minimum 1 bit.
  - state register.
- States and transitions:
  - IDLE: rdy_o=1. On vld_i, buf <= din, stg <= 0, go to CALC.
  - CALC: each cycle apply butterfly stage stg with h = 2^stg: for every i with bit stg of i = 0, buf[i] <= buf[i] ^ buf[i+h]; buf[i+h] is unchanged. stg increments. After the stage with stg=7, wc <= 0 and go to SEND.
  - SEND: vld_o=1, dout = buf[DW*wc +: DW], so word 0 carries x[DW-1:0].
    - sop_o = (wc==0); eop_o = (wc==256/DW-1).
    - On rdy_i: wc increments. If the word was the last one, go to IDLE.
- Result: x_j = XOR of u_i over all i whose set bits include all set bits of j. This is natural order, with no bit reversal.
- Drops: vld_i in CALC or SEND leaves buf untouched. err_o=1 on the next cycle for exactly one cycle.
- Output stability: while vld_o && !rdy_i, dout, sop_o and eop_o hold stable.
- Idle outputs: in every state other than SEND, vld_o, sop_o and eop_o are 0 and dout is 0.
- Register outputs: rdy_o, vld_o, sop_o, eop_o, err_o and dout are decoded from registers only, with no combinational path from vld_i, din or rdy_i.

## Timing
- Reset values: state IDLE, buf=0, stg=0, wc=0; rdy_o=1, err_o=0, vld_o=0, sop_o=0, eop_o=0, dout=0.
- Reset mid-operation: rst asserted in any state returns the block to the reset values immediately, asynchronously. The in-flight frame is discarded and no word of it appears after rst is released.
- Capture and compute:
  - vld_i high in cycle 0 while in IDLE → capture at the end of cycle 0.
  - rdy_o=0 from cycle 1.
  - CALC occupies cycles 1–8.
- First word: vld_o=1 and sop_o=1 in cycle 9.
- Streaming with rdy_i held 1:
  - Words appear in cycles 9 .. 8+256/DW; with DW=32 that is cycles 9–16, eop_o in cycle 16.
  - IDLE and rdy_o=1 in cycle 17, so a new frame can be captured in cycle 17.
  - Peak throughput is one frame per 9+256/DW cycles.
- Backpressure: rdy_i=0 stretches SEND cycle-for-cycle, with no lost or duplicated words.
- Simultaneous last handshake and vld_i: the frame is dropped (rdy_o was 0) and err_o pulses; the new frame is not captured.
- DW=256: SEND lasts 1 cycle when rdy_i=1, with sop_o=eop_o=1.

## Test plan
- Reset: assert rst mid-SEND → vld_o=0, dout=0 and rdy_o=1 at once. After release, no residual words appear and the next frame encodes correctly.
- Unit vectors, DW=32:
  - din with only bit 0 set → x = 256'h1; word0=32'h1, words 1–7 = 0.
  - din with only bit 255 set → all 8 words = 32'hFFFFFFFF.
  - din with only bit 1 set → word0=32'h3.
- Latency: vld_i in cycle 0 with rdy_i=1 → sop_o in cycle 9, eop_o in cycle 16, rdy_o=1 in cycle 17. A back-to-back frame captured in cycle 17 is output correctly.
- Backpressure: random rdy_i at 50% on random din → stream matches the reference-model x word for word. dout/sop_o/eop_o hold while stalled; exactly 8 handshakes occur per frame.
- Overflow: vld_i in cycle 4 while in CALC → err_o=1 in cycle 5 only, and the first frame's output is unaffected.
- Regression: 10k random frames through the full chain behind the bit-mixing stage at random DW from {8, 32, 256} → all codewords match the model, and err_o never fires when the source spacing is at least 9+256/DW cycles.
